// File: rtl/mmu_pkg.sv
// Types and address-map helpers shared by the MMU-side blocks.
// Pure definitions: no logic, no latency.
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    localparam logic [15:0] HRAM_LO = 16'hFF80;
    localparam logic [15:0] HRAM_HI = 16'hFFFE;

    function automatic logic in_hram(input logic [15:0] addr);
        return (addr >= HRAM_LO) && (addr <= HRAM_HI);
    endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer and single MMU bus master; copies DMA_LEN bytes from {src_hi,00} to OAM_BASE.
// START_DELAY + 2*DMA_LEN cycles per transfer; each CPU HRAM access while busy stalls the engine one cycle.
module oam_dma_controller
    import mmu_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          DMA_LEN      = 160,
    parameter int          START_DELAY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    localparam int IW = $clog2(DMA_LEN);
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DMA_LEN - 1);
    localparam logic [DW-1:0] DLY_LAST = DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);

    dma_state_t    state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [DW-1:0] dly, dly_nxt;
    logic [7:0]    src_hi;
    logic [7:0]    byte_buf;
    logic [7:0]    src_eff;

    logic cpu_wr, cpu_rd, reg_hit, hram_hit, trigger, stall;

    // Write beats read when the CPU asserts both strobes.
    assign cpu_wr   = cpu_write_en;
    assign cpu_rd   = cpu_read_en & ~cpu_write_en;
    assign reg_hit  = (cpu_addr == DMA_REG_ADDR);
    assign hram_hit = (cpu_rd | cpu_wr) & in_hram(cpu_addr);
    assign trigger  = cpu_wr & reg_hit;
    assign stall    = hram_hit & (state != IDLE);
    // Sources above DFxx alias onto work RAM, as echo RAM does.
    assign src_eff  = (src_hi > 8'hDF) ? (src_hi - 8'h20) : src_hi;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dly_nxt   = dly;
        if (trigger) begin
            idx_nxt   = '0;
            dly_nxt   = '0;
            state_nxt = (START_DELAY == 0) ? READ : START;
        end else if (!stall) begin
            unique case (state)
                IDLE:  state_nxt = IDLE;
                START: begin
                    if (dly == DLY_LAST) begin
                        state_nxt = READ;
                    end else begin
                        dly_nxt = dly + 1'b1;
                    end
                end
                READ:  state_nxt = WRITE;
                WRITE: begin
                    if (idx == IDX_LAST) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = READ;
                        idx_nxt   = idx + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            dly        <= '0;
            src_hi     <= 8'hFF;
            byte_buf   <= 8'h00;
            dma_active <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            dly        <= dly_nxt;
            dma_active <= (state_nxt != IDLE);
            if (trigger) begin
                src_hi <= cpu_wdata;
            end
            if ((state == READ) && !stall) begin
                byte_buf <= mem_rdata;
            end
        end
    end

    // Bus mux: the register write itself never reaches the MMU.
    always_comb begin
        mem_addr     = 16'h0000;
        mem_wdata    = 8'h00;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        cpu_rdata    = 8'hFF;
        if (reset) begin
            if (state == IDLE) begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (reg_hit) begin
                    if (cpu_rd) begin
                        cpu_rdata = src_hi;
                    end
                end else begin
                    mem_read_en  = cpu_rd;
                    mem_write_en = cpu_wr;
                    cpu_rdata    = mem_rdata;
                end
            end else if (hram_hit) begin
                mem_addr     = cpu_addr;
                mem_wdata    = cpu_wdata;
                mem_read_en  = cpu_rd;
                mem_write_en = cpu_wr;
                cpu_rdata    = mem_rdata;
            end else begin
                if (cpu_rd && reg_hit) begin
                    cpu_rdata = src_hi;
                end
                if (state == READ) begin
                    mem_addr    = {src_eff, 8'(idx)};
                    mem_read_en = 1'b1;
                end else if (state == WRITE) begin
                    mem_addr     = OAM_BASE + 16'(idx);
                    mem_wdata    = byte_buf;
                    mem_write_en = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Randomised scoreboard bench for oam_dma_controller against a byte-level transfer model.
module tb_oam_dma_controller;
    import mmu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read_en, cpu_write_en;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_read_en, mem_write_en;
    logic        dma_active;

    always #5 clk = ~clk;

    oam_dma_controller dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_rdata(mem_rdata),
        .dma_active(dma_active)
    );

    // Memory behind the MMU: unwritten bytes read a seeded pattern.
    logic [7:0] mem     [0:65535];
    bit         wr_flag [0:65535];
    logic [7:0] seed;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return 8'(a[7:0] * 8'd37) ^ 8'(a[15:8] * 8'd91) ^ seed;
    endfunction

    function automatic logic [7:0] rd(input logic [15:0] a);
        return wr_flag[a] ? mem[a] : pat(a);
    endfunction

    assign mem_rdata = rd(mem_addr);

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr]     <= mem_wdata;
            wr_flag[mem_addr] <= 1'b1;
        end
    end

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t        dma_q[$];
    ev_t        mon_e;
    logic [7:0] model_src = 8'hFF;
    logic       exp_fwd = 1'b0, exp_we = 1'b0, exp_re = 1'b0, exp_rd = 1'b0;
    logic [15:0] exp_addr = 16'h0;
    logic [7:0] exp_wdata = 8'h0, exp_rdata = 8'h0;
    int vectors = 0, miscompares = 0;
    int pops = 0, cyc = 0, trig_cyc = 0, act_run = 0, last_len = 0;
    bit await_first = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the next expected bus event whenever the DUT strobes the MMU.
    always @(negedge clk) begin
        chk("strobe_exclusive", 32'(mem_read_en & mem_write_en), 0);
        chk("dma_active", 32'(dma_active), 32'(dma_q.size() != 0));
        if (!reset) begin
            chk("reset_mem_bus", {mem_addr, mem_wdata, 6'd0, mem_read_en, mem_write_en}, 0);
        end
        if (exp_fwd) begin
            chk("fwd_addr", 32'(mem_addr), 32'(exp_addr));
            chk("fwd_strobes", {30'd0, mem_read_en, mem_write_en}, {30'd0, exp_re, exp_we});
            if (exp_we) chk("fwd_wdata", 32'(mem_wdata), 32'(exp_wdata));
        end else if (mem_read_en || mem_write_en) begin
            if (dma_q.size() == 0) begin
                chk("spurious_strobe", {mem_addr, 14'd0, mem_read_en, mem_write_en}, 0);
            end else begin
                mon_e = dma_q.pop_front();
                pops++;
                if (await_first) begin
                    chk("first_read_latency", 32'(cyc - trig_cyc), 2);
                    await_first = 1'b0;
                end
                chk("dma_addr", 32'(mem_addr), 32'(mon_e.addr));
                chk("dma_kind", {30'd0, mem_read_en, mem_write_en}, {30'd0, ~mon_e.we, mon_e.we});
                if (mon_e.we) chk("dma_wdata", 32'(mem_wdata), 32'(mon_e.data));
            end
        end
        if (exp_rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
        if (dma_active) begin
            act_run++;
        end else if (act_run > 0) begin
            last_len = act_run;
            act_run  = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cpu_op(input bit r, input bit w, input logic [15:0] a, input logic [7:0] d);
        bit act;
        bit regh;
        act  = (dma_q.size() != 0);
        regh = (a == 16'hFF46);
        cpu_read_en = r; cpu_write_en = w; cpu_addr = a; cpu_wdata = d;
        exp_we = w; exp_re = r & ~w; exp_addr = a; exp_wdata = d;
        exp_fwd = act ? in_hram(a) : !regh;
        exp_rd  = r & ~w;
        if (exp_fwd)   exp_rdata = rd(a);
        else if (regh) exp_rdata = model_src;
        else           exp_rdata = 8'hFF;
        @(posedge clk); #1;
        cpu_read_en = 1'b0; cpu_write_en = 1'b0;
        exp_fwd = 1'b0; exp_rd = 1'b0;
    endtask

    function automatic logic [7:0] eff_of(input logic [7:0] s);
        return (s >= 8'hE0) ? 8'(s - 8'h20) : s;
    endfunction

    task automatic trigger(input logic [7:0] s);
        logic [7:0] e;
        cpu_write_en = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = s;
        exp_fwd = 1'b0; exp_rd = 1'b0; trig_cyc = cyc;
        @(posedge clk); #1;
        cpu_write_en = 1'b0;
        model_src = s;
        e = eff_of(s);
        dma_q.delete();
        pops = 0;
        await_first = 1'b1;
        for (int i = 0; i < 160; i++) begin
            dma_q.push_back('{we: 1'b0, addr: {e, 8'(i)}, data: 8'h00});
            dma_q.push_back('{we: 1'b1, addr: 16'(16'hFE00 + i), data: rd({e, 8'(i)})});
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (dma_q.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, 32'(dma_q.size()), 0);
        dma_q.delete();
        idle(2);
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pops < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_pops_timeout", 32'(pops), 32'(target));
    endtask

    task automatic check_oam(input string name, input logic [7:0] s, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            chk(name, 32'(rd(16'(16'hFE00 + i))), 32'(rd({eff_of(s), 8'(i)})));
        end
    endtask

    logic [7:0]  snap [0:159];
    logic [7:0]  s;
    logic [15:0] a;
    int          hits, kind, gap;
    bit          r, w;

    initial begin
        seed = 8'($urandom);
        reset = 1'b0;
        cpu_addr = 16'h1234; cpu_wdata = 8'h77;
        cpu_read_en = 1'b1; cpu_write_en = 1'b1;
        idle(3);
        cpu_read_en = 1'b0; cpu_write_en = 1'b0;
        reset = 1'b1;
        idle(1);

        // Pass-through while idle.
        cpu_op(1, 0, 16'h9000, 8'h00);
        cpu_op(0, 1, 16'h9001, 8'h5A);
        cpu_op(1, 0, 16'h9001, 8'h00);
        cpu_op(1, 1, 16'h9002, 8'hA5);
        cpu_op(1, 0, 16'hFF46, 8'h00);
        cpu_op(1, 0, 16'hFF90, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cpu_op(1'($urandom), 1'b1, 16'(16'h9100 + $urandom_range(0, 255)), 8'($urandom));
            cpu_op(1'b1, 1'b0, 16'(16'h9100 + $urandom_range(0, 255)), 8'h00);
        end

        trigger(8'hC1);
        wait_done("c1");
        chk("c1_active_len", 32'(last_len), 321);
        check_oam("c1_oam", 8'hC1, 0, 159);
        cpu_op(1, 0, 16'hFF46, 8'h00);

        trigger(8'hF0);
        wait_done("f0");
        chk("f0_active_len", 32'(last_len), 321);
        check_oam("f0_oam", 8'hF0, 0, 159);

        // Gated accesses plus one HRAM read stall.
        trigger(8'h80);
        idle(10);
        cpu_op(1, 0, 16'hC000, 8'h00);
        idle(3);
        cpu_op(0, 1, 16'h8000, 8'h3C);
        cpu_op(1, 0, 16'hFF46, 8'h00);
        cpu_op(1, 0, 16'hFF90, 8'h00);
        wait_done("stall");
        chk("stall_active_len", 32'(last_len), 322);
        check_oam("stall_oam", 8'h80, 0, 159);

        // Random CPU traffic during a transfer.
        s = 8'($urandom_range(8'h80, 8'hFF));
        trigger(s);
        hits = 0;
        idle(2);
        while (dma_q.size() > 6) begin
            kind = $urandom_range(0, 3);
            w = 1'($urandom);
            r = w ? 1'($urandom) : 1'b1;
            if (kind == 0)      a = 16'(16'hFF80 + $urandom_range(0, 126));
            else if (kind == 1) begin a = 16'hFF46; w = 1'b0; r = 1'b1; end
            else                a = 16'($urandom);
            if (w && a == 16'hFF46) a = 16'h8000;
            if (in_hram(a)) hits++;
            cpu_op(r, w, a, 8'($urandom));
            gap = $urandom_range(0, 3);
            idle(gap);
        end
        wait_done("rand");
        chk("rand_active_len", 32'(last_len), 32'(321 + hits));
        check_oam("rand_oam", s, 0, 159);

        // Restart mid-transfer at idx 50.
        trigger(8'hC1);
        wait_pops(100);
        trigger(8'hC2);
        wait_done("restart");
        chk("restart_active_len", 32'(last_len), 423);
        check_oam("restart_oam", 8'hC2, 0, 159);

        // Reset at idx 80 aborts the copy.
        for (int i = 0; i < 160; i++) snap[i] = rd(16'(16'hFE00 + i));
        s = 8'($urandom_range(8'hC3, 8'hDF));
        trigger(s);
        wait_pops(160);
        reset = 1'b0;
        dma_q.delete();
        model_src = 8'hFF;
        idle(3);
        reset = 1'b1;
        idle(2);
        check_oam("abort_oam_head", s, 0, 79);
        for (int i = 80; i < 160; i++) begin
            chk("abort_oam_untouched", 32'(rd(16'(16'hFE00 + i))), 32'(snap[i]));
        end
        cpu_op(1, 0, 16'hFF46, 8'h00);
        cpu_op(1, 0, 16'h9001, 8'h00);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
